int_issue_queue: RTL and testbench
==================================

// Module: int_issue_queue
// PURPOSE
//  Integer issue queue directly downstream of dispatch. Buffers up to DEPTH
//  dispatched uops and tracks per-source sleep bits, set from busy-table reads
//  at enqueue and cleared by writeback wakeups. Each cycle it issues the oldest
//  ready uop to the integer execution unit over a valid/ready handshake.
//  Storage is collapsing: index 0 always holds the oldest entry.
// PARAMETERS
//  DEPTH    8    number of entries (>=2)
//  DATA_W   281  uop payload width (`ISQ_DATA_WIDTH)
//  PREG_W   6    physical register index width
// PORTS
//  clock                         in   1       single clock
//  reset_n                       in   1       synchronous, active-low reset
//  disp2intisq_enq_valid         in   1       dispatch offers a uop
//  disp2intisq_instr0_enq_data   in   DATA_W  payload: prs1[116:111], prs2[110:105], src1_is_reg[104], src2_is_reg[103]
//  bt2isq_rs1_busy               in   1       busy-table read for prs1 (pre-update value)
//  bt2isq_rs2_busy               in   1       busy-table read for prs2
//  intisq_can_enq                out  1       queue has a free entry
//  intisq2disp_enq_ready         out  1       equals intisq_can_enq
//  wb0_valid, wb1_valid          in   1 each  writeback wakeup strobes
//  wb0_prd, wb1_prd              in   PREG_W  woken physical registers
//  intisq2exu_valid              out  1       issue candidate valid
//  intisq2exu_data               out  DATA_W  payload of the issued uop
//  exu2intisq_ready              in   1       EXU accepts
//  flush_valid                   in   1       pipeline flush
//  intisq_count                  out  $clog2(DEPTH+1)  occupied entries
// BEHAVIOUR
//  - Reset (reset_n==0 at posedge): all entry valid bits 0, count 0. Outputs: can_enq=1, exu_valid=0, data=0.
//  - Enqueue fires on enq_valid && can_enq && !flush_valid. Offers while full are ignored; dispatch holds them.
//  - can_enq = (count < DEPTH). An issue in the same cycle gives no credit.
//  - Sleep on enqueue: sleepN = src_is_reg && prsN!=0 && busyN && !(wake match on prsN this cycle).
//    The same-cycle wake match bypasses the stale busy read.
//  - Wakeup: every valid entry clears sleepN when wbK_valid && wbK_prd==prsN (K=0,1). Both ports act in the same cycle.
//  - Entry is ready when valid && !sleep1 && !sleep2. Select picks the lowest ready index.
//    exu_valid and exu_data are combinational from the entry registers; wakeups take effect the next cycle.
//  - Latency: a uop enqueued in cycle N and ready has exu_valid=1 in cycle N+1 at the earliest.
//  - Issue fires on exu_valid && exu_ready. Entries above the issued index shift down by one.
//    With a simultaneous enqueue, the new uop lands at index count-1; otherwise it lands at index count.
//  - count' = count + enq_fire - issue_fire. No wrap is possible; count never exceeds DEPTH.
//  - While an entry is not ready, exu_valid stays 0 and the payload does not care.
//    While an issue is stalled (!exu_ready), the selected entry and its payload stay stable.
//    An older entry becoming ready may preempt it.
//  - flush_valid: the same cycle forces exu_valid=0 and suppresses enq/issue. Next edge: all valid bits 0, count 0.
//  - Reset asserted mid-operation behaves as flush plus perf counter clear.
// CONFIGURATION
//  INTISQ_PERF_EN defined: adds outputs perf_full_cycles[31:0] and perf_issue_cnt[31:0].
//    perf_full_cycles increments every cycle with count==DEPTH.
//    perf_issue_cnt increments on each issue fire.
//    Both counters wrap modulo 2^32, reset to 0, and are not cleared by flush.
//  INTISQ_PERF_EN undefined: these ports and their counters do not exist. Functional behaviour is identical.
// TESTING
//  1. Enq uop with prs1=5, prs2=0, busy1=0, exu_ready=1 -> exu_valid=1 next cycle; payload matches; count 1->0 after fire.
//  2. Enq prs1=7 busy1=1 -> no issue. wb0_valid, prd=7 in cycle 3 -> exu_valid=1 in cycle 4.
//  3. Enq with busy1=1 while wb1_prd==prs1 in the same cycle -> entry enqueued awake; issues next cycle.
//  4. Fill 8 entries, exu_ready=0 -> can_enq=0, 9th offer dropped.
//     Raise exu_ready -> issue order = enqueue order (robids 0..7).
//  5. Entry0 asleep, entry1 ready -> entry1 issues first; entry2 shifts to index 1; entry0 stays at index 0.
//  6. Count=5, assert flush_valid with enq_valid=1 -> exu_valid=0 that cycle; count=0, can_enq=1 next cycle.

Source files
------------

// File: rtl/int_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : int_issue_queue
// Brief    : Collapsing integer issue queue with source wakeup and oldest-ready
//            select. Optional perf counters under `INTISQ_PERF_EN.
// Revision : 1.0
// ============================================================================
module int_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 281,
    parameter int PREG_W = 6
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       disp2intisq_enq_valid,
    input  logic [DATA_W-1:0]          disp2intisq_instr0_enq_data,
    input  logic                       bt2isq_rs1_busy,
    input  logic                       bt2isq_rs2_busy,
    output logic                       intisq_can_enq,
    output logic                       intisq2disp_enq_ready,
    input  logic                       wb0_valid,
    input  logic                       wb1_valid,
    input  logic [PREG_W-1:0]          wb0_prd,
    input  logic [PREG_W-1:0]          wb1_prd,
    output logic                       intisq2exu_valid,
    output logic [DATA_W-1:0]          intisq2exu_data,
    input  logic                       exu2intisq_ready,
    input  logic                       flush_valid,
    output logic [$clog2(DEPTH+1)-1:0] intisq_count
`ifdef INTISQ_PERF_EN
    ,
    output logic [31:0]                perf_full_cycles,
    output logic [31:0]                perf_issue_cnt
`endif
);

    localparam int CNT_W    = $clog2(DEPTH+1);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int PRS1_LSB = 111;
    localparam int PRS2_LSB = 105;
    localparam int SRC1_BIT = 104;
    localparam int SRC2_BIT = 103;

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_sleep1;
    logic [DEPTH-1:0]  r_sleep2;
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CNT_W-1:0]  r_count;

    logic [DEPTH-1:0]  w_wk_s1;
    logic [DEPTH-1:0]  w_wk_s2;
    logic [DEPTH-1:0]  w_ready;
    logic [IDX_W-1:0]  w_sel;
    logic              w_any;
    logic              w_issue;
    logic              w_enq;
    logic [CNT_W-1:0]  w_enq_idx;
    logic [PREG_W-1:0] w_in_p1;
    logic [PREG_W-1:0] w_in_p2;
    logic              w_in_s1;
    logic              w_in_s2;

    logic [DEPTH-1:0]  w_nv;
    logic [DEPTH-1:0]  w_ns1;
    logic [DEPTH-1:0]  w_ns2;
    logic [DATA_W-1:0] w_nd [DEPTH];

    function automatic logic f_wake(
        input logic [PREG_W-1:0] p,
        input logic              v0,
        input logic [PREG_W-1:0] d0,
        input logic              v1,
        input logic [PREG_W-1:0] d1
    );
        return (v0 && (d0 == p)) || (v1 && (d1 == p));
    endfunction

    // Stored sleep bits with this cycle's wakeups applied; these feed the next state.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wake
            assign w_wk_s1[gi] = r_sleep1[gi] &
                ~f_wake(r_data[gi][PRS1_LSB +: PREG_W], wb0_valid, wb0_prd, wb1_valid, wb1_prd);
            assign w_wk_s2[gi] = r_sleep2[gi] &
                ~f_wake(r_data[gi][PRS2_LSB +: PREG_W], wb0_valid, wb0_prd, wb1_valid, wb1_prd);
        end
    endgenerate

    assign w_ready = r_valid & ~r_sleep1 & ~r_sleep2;

    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = DEPTH-1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel = IDX_W'(i);
                w_any = 1'b1;
            end
        end
    end

    assign intisq2exu_valid      = w_any & ~flush_valid;
    assign intisq2exu_data       = w_any ? r_data[w_sel] : '0;
    assign w_issue               = intisq2exu_valid & exu2intisq_ready;
    assign intisq_can_enq        = (r_count < CNT_W'(DEPTH));
    assign intisq2disp_enq_ready = intisq_can_enq;
    assign intisq_count          = r_count;
    assign w_enq                 = disp2intisq_enq_valid & intisq_can_enq & ~flush_valid;
    assign w_enq_idx             = r_count - CNT_W'(w_issue);

    // A wakeup in the enqueue cycle overrides the stale busy-table read.
    assign w_in_p1 = disp2intisq_instr0_enq_data[PRS1_LSB +: PREG_W];
    assign w_in_p2 = disp2intisq_instr0_enq_data[PRS2_LSB +: PREG_W];
    assign w_in_s1 = disp2intisq_instr0_enq_data[SRC1_BIT] && (w_in_p1 != '0) && bt2isq_rs1_busy &&
                     !f_wake(w_in_p1, wb0_valid, wb0_prd, wb1_valid, wb1_prd);
    assign w_in_s2 = disp2intisq_instr0_enq_data[SRC2_BIT] && (w_in_p2 != '0) && bt2isq_rs2_busy &&
                     !f_wake(w_in_p2, wb0_valid, wb0_prd, wb1_valid, wb1_prd);

    always_comb begin
        int  src;
        logic shift;
        w_nv  = '0;
        w_ns1 = '0;
        w_ns2 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_nd[i] = r_data[i];
        end
        for (int i = 0; i < DEPTH; i++) begin
            src   = i;
            shift = w_issue && (i >= int'(w_sel));
            if (shift && (i < DEPTH-1)) begin
                src = i + 1;
            end
            w_nv[i]  = r_valid[src] & ~(shift && (i == DEPTH-1));
            w_ns1[i] = w_wk_s1[src];
            w_ns2[i] = w_wk_s2[src];
            w_nd[i]  = r_data[src];
            if (w_enq && (i == int'(w_enq_idx))) begin
                w_nv[i]  = 1'b1;
                w_ns1[i] = w_in_s1;
                w_ns2[i] = w_in_s2;
                w_nd[i]  = disp2intisq_instr0_enq_data;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n || flush_valid) begin
            r_valid  <= '0;
            r_sleep1 <= '0;
            r_sleep2 <= '0;
            r_count  <= '0;
        end else begin
            r_valid  <= w_nv;
            r_sleep1 <= w_ns1;
            r_sleep2 <= w_ns2;
            r_count  <= r_count + CNT_W'(w_enq) - CNT_W'(w_issue);
        end
    end

    // Payload is qualified by the valid bits, so it needs no reset.
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            r_data[i] <= w_nd[i];
        end
    end

`ifdef INTISQ_PERF_EN
    logic [31:0] r_perf_full;
    logic [31:0] r_perf_issue;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_perf_full  <= '0;
            r_perf_issue <= '0;
        end else begin
            if (r_count == CNT_W'(DEPTH)) begin
                r_perf_full <= r_perf_full + 32'd1;
            end
            if (w_issue) begin
                r_perf_issue <= r_perf_issue + 32'd1;
            end
        end
    end

    assign perf_full_cycles = r_perf_full;
    assign perf_issue_cnt   = r_perf_issue;
`else
    // No performance counters in this build.
`endif

endmodule
`default_nettype wire

// File: tb/tb_int_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_int_issue_queue
// Brief    : Self-checking bench for int_issue_queue (vector table + scoreboard).
// Revision : 1.0
// ============================================================================
module tb_int_issue_queue;
    localparam int DEPTH  = 8;
    localparam int DATA_W = 281;
    localparam int PREG_W = 6;
    localparam int CNT_W  = $clog2(DEPTH+1);

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic              enq_valid = 1'b0;
    logic [DATA_W-1:0] enq_data = '0;
    logic              busy1 = 1'b0;
    logic              busy2 = 1'b0;
    logic              can_enq;
    logic              enq_ready;
    logic              wb0v = 1'b0;
    logic              wb1v = 1'b0;
    logic [PREG_W-1:0] wb0p = '0;
    logic [PREG_W-1:0] wb1p = '0;
    logic              exu_valid;
    logic [DATA_W-1:0] exu_data;
    logic              exu_ready = 1'b0;
    logic              flush = 1'b0;
    logic [CNT_W-1:0]  count;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] sb_q [$];

    int_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .PREG_W(PREG_W)) dut (
        .clock                       (clock),
        .reset_n                     (reset_n),
        .disp2intisq_enq_valid       (enq_valid),
        .disp2intisq_instr0_enq_data (enq_data),
        .bt2isq_rs1_busy             (busy1),
        .bt2isq_rs2_busy             (busy2),
        .intisq_can_enq              (can_enq),
        .intisq2disp_enq_ready       (enq_ready),
        .wb0_valid                   (wb0v),
        .wb1_valid                   (wb1v),
        .wb0_prd                     (wb0p),
        .wb1_prd                     (wb1p),
        .intisq2exu_valid            (exu_valid),
        .intisq2exu_data             (exu_data),
        .exu2intisq_ready            (exu_ready),
        .flush_valid                 (flush),
        .intisq_count                (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] p1;
        logic [5:0] p2;
        logic       r1;
        logic       r2;
        logic       b1;
        logic       b2;
        logic       w0v;
        logic [5:0] w0p;
        logic       w1v;
        logic [5:0] w1p;
        logic       rdy;
    } vec_t;

    vec_t vt [8];

    function automatic logic [DATA_W-1:0] mk(input logic [7:0] robid, input logic [5:0] p1,
                                             input logic [5:0] p2, input logic r1, input logic r2);
        logic [DATA_W-1:0] d;
        d = '0;
        d[7:0]          = robid;
        d[207:200]      = robid ^ 8'h5a;
        d[DATA_W-1 -: 8] = ~robid;
        d[116:111]      = p1;
        d[110:105]      = p2;
        d[104]          = r1;
        d[103]          = r2;
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Compare any issue happening this cycle against the scoreboard, then advance one edge.
    task automatic tick;
        logic [DATA_W-1:0] exp;
        #1;
        if (exu_valid === 1'b1 && exu_ready === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got robid %0h, expected no issue", exu_data[7:0]);
            end else begin
                exp = sb_q.pop_front();
                if (exu_data !== exp) begin
                    errors++;
                    $display("FAIL issue_data: got robid %0h data %0h expected robid %0h data %0h",
                             exu_data[7:0], exu_data, exp[7:0], exp);
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        vt[0] = '{6'd5,  6'd0,  1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b1};
        vt[1] = '{6'd7,  6'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b0, 6'd0,  1'b0};
        vt[2] = '{6'd9,  6'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6'd0,  1'b1, 6'd9,  1'b1};
        vt[3] = '{6'd3,  6'd4,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b1};
        vt[4] = '{6'd0,  6'd12, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 6'd12, 1'b0, 6'd0,  1'b1};
        vt[5] = '{6'd20, 6'd21, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 6'd20, 1'b0, 6'd0,  1'b0};
        vt[6] = '{6'd0,  6'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0,  1'b0, 6'd0,  1'b1};
        vt[7] = '{6'd40, 6'd41, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0,  1'b1, 6'd41, 1'b0};

        repeat (3) tick;
        chk("rst_count", 32'(count), 0);
        chk("rst_can_enq", 32'(can_enq), 1);
        chk("rst_enq_ready", 32'(enq_ready), 1);
        chk("rst_exu_valid", 32'(exu_valid), 0);
        chk("rst_exu_data", exu_data[31:0], 0);
        reset_n = 1'b1;
        tick;

        // Single-uop vectors: sleep decision at enqueue, wakeup, one-cycle issue latency.
        for (int k = 0; k < 8; k++) begin
            exu_ready = 1'b1;
            enq_valid = 1'b1;
            enq_data  = mk(8'(k + 32), vt[k].p1, vt[k].p2, vt[k].r1, vt[k].r2);
            busy1 = vt[k].b1;  busy2 = vt[k].b2;
            wb0v  = vt[k].w0v; wb0p  = vt[k].w0p;
            wb1v  = vt[k].w1v; wb1p  = vt[k].w1p;
            sb_q.push_back(enq_data);
            tick;
            enq_valid = 1'b0; busy1 = 1'b0; busy2 = 1'b0; wb0v = 1'b0; wb1v = 1'b0;
            #1;
            chk($sformatf("v%0d_valid", k), 32'(exu_valid), 32'(vt[k].rdy));
            chk($sformatf("v%0d_count", k), 32'(count), 1);
            if (!vt[k].rdy) begin
                tick;
                chk($sformatf("v%0d_still_asleep", k), 32'(exu_valid), 0);
                wb0v = 1'b1; wb0p = vt[k].p1;
                wb1v = 1'b1; wb1p = vt[k].p2;
                #1;
                chk($sformatf("v%0d_wake_cycle", k), 32'(exu_valid), 0);
                tick;
                wb0v = 1'b0; wb1v = 1'b0;
                #1;
                chk($sformatf("v%0d_woken", k), 32'(exu_valid), 1);
            end
            tick;
            chk($sformatf("v%0d_count_after", k), 32'(count), 0);
        end

        // Fill to DEPTH with issue stalled; extra offer is dropped; drain in order.
        exu_ready = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            enq_valid = 1'b1;
            enq_data  = mk(8'(k), 6'd0, 6'd0, 1'b0, 1'b0);
            sb_q.push_back(enq_data);
            tick;
        end
        enq_valid = 1'b0;
        chk("full_can_enq", 32'(can_enq), 0);
        chk("full_enq_ready", 32'(enq_ready), 0);
        chk("full_count", 32'(count), DEPTH);
        chk("full_stall_robid", 32'(exu_data[7:0]), 0);
        enq_valid = 1'b1;
        enq_data  = mk(8'd99, 6'd0, 6'd0, 1'b0, 1'b0);
        tick;
        enq_valid = 1'b0;
        chk("full_drop_count", 32'(count), DEPTH);
        exu_ready = 1'b1;
        repeat (DEPTH) tick;
        chk("drain_count", 32'(count), 0);
        chk("drain_can_enq", 32'(can_enq), 1);

        // Sleeping oldest entry is bypassed; enqueue concurrent with issue lands behind.
        exu_ready = 1'b0;
        enq_valid = 1'b1;
        enq_data  = mk(8'd10, 6'd30, 6'd0, 1'b1, 1'b0);
        busy1 = 1'b1;
        tick;
        busy1 = 1'b0;
        enq_data = mk(8'd11, 6'd0, 6'd0, 1'b0, 1'b0);
        tick;
        enq_data = mk(8'd12, 6'd0, 6'd0, 1'b0, 1'b0);
        tick;
        enq_valid = 1'b0;
        #1;
        chk("pre_sel_valid", 32'(exu_valid), 1);
        chk("pre_sel_robid", 32'(exu_data[7:0]), 32'h11 - 32'h6);
        tick;
        chk("stall_stable_robid", 32'(exu_data[7:0]), 11);
        exu_ready = 1'b1;
        sb_q.push_back(mk(8'd11, 6'd0, 6'd0, 1'b0, 1'b0));
        enq_valid = 1'b1;
        enq_data  = mk(8'd13, 6'd0, 6'd0, 1'b0, 1'b0);
        tick;
        enq_valid = 1'b0;
        chk("enq_issue_count", 32'(count), 3);
        sb_q.push_back(mk(8'd12, 6'd0, 6'd0, 1'b0, 1'b0));
        sb_q.push_back(mk(8'd13, 6'd0, 6'd0, 1'b0, 1'b0));
        tick;
        tick;
        chk("sleeper_count", 32'(count), 1);
        #1;
        chk("sleeper_valid", 32'(exu_valid), 0);
        wb0v = 1'b1; wb0p = 6'd30;
        tick;
        wb0v = 1'b0;
        sb_q.push_back(mk(8'd10, 6'd30, 6'd0, 1'b1, 1'b0));
        #1;
        chk("sleeper_woken", 32'(exu_valid), 1);
        tick;
        chk("sleeper_done_count", 32'(count), 0);

        // Flush with a concurrent offer.
        exu_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            enq_valid = 1'b1;
            enq_data  = mk(8'(64 + k), 6'd0, 6'd0, 1'b0, 1'b0);
            tick;
        end
        chk("preflush_count", 32'(count), 5);
        flush = 1'b1; exu_ready = 1'b1; enq_valid = 1'b1;
        #1;
        chk("flush_exu_valid", 32'(exu_valid), 0);
        tick;
        flush = 1'b0; enq_valid = 1'b0; exu_ready = 1'b0;
        chk("flush_count", 32'(count), 0);
        chk("flush_can_enq", 32'(can_enq), 1);
        #1;
        chk("flush_after_valid", 32'(exu_valid), 0);
        exu_ready = 1'b1;
        enq_valid = 1'b1;
        enq_data  = mk(8'd80, 6'd0, 6'd0, 1'b0, 1'b0);
        sb_q.push_back(enq_data);
        tick;
        enq_valid = 1'b0;
        tick;
        chk("post_flush_count", 32'(count), 0);

        // Reset mid-operation empties the queue.
        exu_ready = 1'b0;
        enq_valid = 1'b1;
        enq_data  = mk(8'd90, 6'd0, 6'd0, 1'b0, 1'b0);
        tick;
        tick;
        enq_valid = 1'b0;
        chk("mid_pre_count", 32'(count), 2);
        reset_n = 1'b0;
        tick;
        reset_n = 1'b1;
        #1;
        chk("mid_rst_count", 32'(count), 0);
        chk("mid_rst_valid", 32'(exu_valid), 0);
        chk("mid_rst_data", exu_data[31:0], 0);

        chk("sb_empty", 32'(sb_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
